// File: rtl/hex_msg_scroller.sv
// Latched LOSE/PASS status display for the seven-segment bank, with optional
// leftward scrolling of an 8-character message ring at a divided tick rate.
module hex_msg_scroller #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned TICK_DIV   = 25000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    lose,
   input  logic                    pass,
   input  logic                    clear,
   input  logic                    scroll_en,
   output logic [7*NUM_DIGITS-1:0] hex,
   output logic                    busy
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOSE = 2'd1;
   localparam logic [1:0] S_PASS = 2'd2;

   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_L     = 7'b1000111;
   localparam logic [6:0] G_O     = 7'b1000000;
   localparam logic [6:0] G_S     = 7'b0010010;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_P     = 7'b0001100;
   localparam logic [6:0] G_A     = 7'b0001000;
   localparam logic [6:0] G_BLANK = 7'b1111111;

   logic [1:0]       state, state_nxt;
   logic [2:0]       pos, pos_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             tick;

   // Character at ring index i for the LOSE ("-LOSE-  ") or PASS ("-PASS-  ") ring
   function automatic logic [6:0] glyph(input logic is_pass, input logic [2:0] i);
      logic [6:0] g;
      g = G_BLANK;
      case (i)
         3'd0, 3'd5: g = G_DASH;
         3'd1:       g = is_pass ? G_P : G_L;
         3'd2:       g = is_pass ? G_A : G_O;
         3'd3:       g = G_S;
         3'd4:       g = is_pass ? G_S : G_E;
         default:    g = G_BLANK;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         pos   <= 3'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request priority: clear, then lose (overrides pass), then pass from idle only
   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      cnt_nxt   = cnt;
      tick      = (cnt == CNT_W'(TICK_DIV - 1));

      if (clear)
         state_nxt = S_IDLE;
      else if (lose && state != S_LOSE)
         state_nxt = S_LOSE;
      else if (pass && state == S_IDLE)
         state_nxt = S_PASS;

      if (state_nxt != state || state == S_IDLE) begin
         pos_nxt = 3'd0;
         cnt_nxt = '0;
      end else begin
         cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
         if (tick && scroll_en)
            pos_nxt = pos + 3'd1;
      end
   end

   // Digit d shows ring[(pos + NUM_DIGITS-1-d) mod 8]; 3-bit add gives the wrap
   always_comb begin
      logic [2:0] idx;
      hex = '1;
      idx = 3'd0;
      if (state != S_IDLE) begin
         for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            idx = pos + 3'(NUM_DIGITS - 1 - d);
            hex[7*d +: 7] = glyph(state == S_PASS, idx);
         end
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: doc/hex_msg_scroller.md
# hex_msg_scroller

Sequential successor to the combinational status display used on the board's six HEX digits. It holds a game result (LOSE or PASS) as latched state until it is cleared. It can also scroll the message leftward across a parametrised number of digits at a divided tick rate. It sits between the game-control FSM, which drives the `lose`, `pass` and `clear` strobes, and the HEX pins.

## Interface

Parameters:
- `NUM_DIGITS`, 6, number of seven-segment digits driven; legal 1..8.
- `TICK_DIV`, 25000000, clock cycles per scroll step; legal ≥ 2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `lose`  in  1  level; request LOSE message.
- `pass`  in  1  level; request PASS message.
- `clear`  in  1  level; return to blank.
- `scroll_en`  in  1  1 = scroll message, 0 = hold current window.
- `hex`  out  `7*NUM_DIGITS`  segment data, active-low, bit order g..a per digit.
  - Digit `d` occupies bits `[7*d+6:7*d]`.
  - Digit `NUM_DIGITS-1` is leftmost.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation

- Glyphs, active-low with bits 6..0 = g..a:
  - '-' = 0111111, 'L' = 1000111, 'O' = 1000000, 'S' = 0010010, 'E' = 0000110.
  - 'P' = 0001100, 'A' = 0001000, blank = 1111111.
- Message rings are 8 characters, indices 0..7:
  - LOSE ring: "-LOSE-" followed by 2 blanks.
  - PASS ring: "-PASS-" followed by 2 blanks.
- State machine has three states: IDLE, SHOW_LOSE, SHOW_PASS.
- Transition priority each cycle, highest first:
  - `clear` = 1: go to IDLE from any state. `lose` and `pass` are ignored that cycle.
  - Else `lose` = 1 and state ≠ SHOW_LOSE: go to SHOW_LOSE. This applies from IDLE and from SHOW_PASS; LOSE overrides PASS.
  - Else `pass` = 1 and state = IDLE: go to SHOW_PASS. `pass` is ignored while in SHOW_LOSE.
  - Else hold state.
- `lose` and `pass` both high in IDLE: go to SHOW_LOSE.
- Re-asserting the request for the current state has no effect; `pos` and the tick counter are not disturbed.
- Scroll pointer `pos`, 3 bits:
  - Cleared to 0 on every state change.
  - Increments modulo 8 on each tick while `scroll_en` = 1 and state ≠ IDLE.
  - Held at its current value while `scroll_en` = 0. It is not cleared.
- Tick counter:
  - Counts 0..`TICK_DIV`-1 and wraps.
  - A tick occurs in the cycle where count = `TICK_DIV`-1.
  - Cleared to 0 on every state change.
  - Held at 0 in IDLE.
- Display decode, combinational from registered state and `pos`:
  - IDLE: all digits blank.
  - SHOW state: digit `d` shows `ring[(pos + NUM_DIGITS-1-d) mod 8]`.
  - `NUM_DIGITS` = 6 with `pos` = 0 gives "-LOSE-" or "-PASS-" across digits 5..0.
- `busy` = (state ≠ IDLE).

## Timing

- Reset (`reset_n` = 0), asynchronous, effective immediately:
  - state = IDLE, `pos` = 0, tick counter = 0.
  - `hex` = all ones, `busy` = 0.
  - Reset mid-scroll blanks the display without waiting for a clock edge.
- Request latency: an input sampled at edge N changes state at edge N. `hex` and `busy` show the new state after that same edge, so they are valid in cycle N+1.
- Scroll rate: the first advance of `pos` occurs `TICK_DIV` cycles after entering a SHOW state. Later advances occur every `TICK_DIV` cycles after that.
- Wrap: `pos` = 7 plus a tick gives `pos` = 0, with no glitch or blank frame.
- Input levels are used as sampled; no edge detection. Inputs are synchronous to `clk`; the upstream block handles synchronisation.

## Test plan

Bench parameters: `TICK_DIV` = 4, `NUM_DIGITS` = 6.

- Reset release with all inputs 0:
  - `hex` = 42'h3FF_FFFF_FFFF, `busy` = 0.
  - Assert `reset_n` = 0 mid-SHOW: `hex` goes all ones before the next edge.
- Pulse `lose` for 1 cycle with `scroll_en` = 0:
  - Next cycle, digits 5..0 = 0111111, 1000111, 1000000, 0010010, 0000110, 0111111.
  - `busy` = 1; display held for 20+ cycles.
- In SHOW_PASS with `scroll_en` = 1:
  - After 4 cycles, digit 5 = 'P' (0001100).
  - After 32 cycles, `pos` has wrapped to 0 and the display again reads "-PASS-".
- `lose` and `pass` asserted in the same cycle from IDLE: SHOW_LOSE.
  - Then `pass` alone: display stays LOSE.
  - Then `lose` while in SHOW_PASS (reached via `clear`, then `pass`): switches to LOSE with `pos` = 0.
- `clear` and `lose` high together in SHOW_PASS:
  - Next cycle: IDLE, display blank.
  - Following cycle, with `lose` still high: SHOW_LOSE.
- Scroll to `pos` = 3, then drop `scroll_en` for 10 cycles: window frozen at `pos` = 3. Re-raise `scroll_en`: `pos` = 4 after at most 4 cycles.
